// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, keeps one I-cache request
// outstanding through an addr_ok/data_ok handshake, and pushes one or two
// instructions per response into the dual-issue instruction FIFO.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'hBFC0_0000,
  parameter int          EXP_ADEL_BIT = 0,
  parameter int          EXP_IBE_BIT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fifo_full,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_addr_ok,
  input  logic        icache_data_ok,
  input  logic [63:0] icache_rdata,
  input  logic        icache_error,
  output logic        write_en1,
  output logic        write_en2,
  output logic [31:0] write_data1,
  output logic [31:0] write_address1,
  output logic [31:0] write_data2,
  output logic [31:0] write_address2,
  output logic [11:0] write_inst_exp1
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_DISCARD,
    S_ERR_WRITE,
    S_HALT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        after_rst;

  // Registered write-port contents, masked on the way out.
  logic        wr_en1_q;
  logic        wr_en2_q;
  logic [31:0] wr_data1_q;
  logic [31:0] wr_addr1_q;
  logic [31:0] wr_data2_q;
  logic [31:0] wr_addr2_q;
  logic [11:0] wr_exp_q;

  logic req_active;
  logic handshake;
  logic in_flight;

  // Issue is allowed in REQ when the FIFO has room, except during reset and
  // the first cycle after it.
  assign req_active = (state == S_REQ) && !rst && !after_rst && !fifo_full;
  assign icache_req = req_active && (pc[1:0] == 2'b00);
  assign handshake  = icache_req && icache_addr_ok;
  assign icache_addr = pc;

  // A redirect must turn any still-pending response into a discard.
  assign in_flight = handshake ||
                     ((state == S_WAIT || state == S_DISCARD) && !icache_data_ok);

  // The FIFO is flushed in a redirect cycle, so nothing may be written then.
  assign write_en1       = wr_en1_q && !redirect_valid;
  assign write_en2       = wr_en2_q && !redirect_valid;
  assign write_data1     = write_en1 ? wr_data1_q : '0;
  assign write_address1  = write_en1 ? wr_addr1_q : '0;
  assign write_inst_exp1 = write_en1 ? wr_exp_q   : '0;
  assign write_data2     = write_en2 ? wr_data2_q : '0;
  assign write_address2  = write_en2 ? wr_addr2_q : '0;

  // Fetch FSM, PC update and registered FIFO write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register here is sequential state, so only non-blocking
      // assignments are used; blocking ones would race with readers.
      state      <= S_REQ;
      pc         <= RESET_PC;
      req_pc     <= '0;
      after_rst  <= 1'b1;
      wr_en1_q   <= 1'b0;
      wr_en2_q   <= 1'b0;
      wr_data1_q <= '0;
      wr_addr1_q <= '0;
      wr_data2_q <= '0;
      wr_addr2_q <= '0;
      wr_exp_q   <= '0;
    end else begin
      after_rst  <= 1'b0;
      // Write slots are single-cycle pulses; clear them unless refilled below.
      wr_en1_q   <= 1'b0;
      wr_en2_q   <= 1'b0;
      wr_data1_q <= '0;
      wr_addr1_q <= '0;
      wr_data2_q <= '0;
      wr_addr2_q <= '0;
      wr_exp_q   <= '0;

      if (redirect_valid) begin
        pc    <= redirect_pc;
        state <= in_flight ? S_DISCARD : S_REQ;
      end else begin
        case (state)
          S_REQ: begin
            if (handshake) begin
              req_pc <= pc;
              state  <= S_WAIT;
            end else if (req_active && (pc[1:0] != 2'b00)) begin
              state <= S_ERR_WRITE;
            end
          end

          S_WAIT: begin
            if (icache_data_ok) begin
              wr_en1_q   <= 1'b1;
              wr_addr1_q <= req_pc;
              if (icache_error) begin
                wr_exp_q[EXP_IBE_BIT] <= 1'b1;
                state <= S_HALT;
              end else begin
                wr_data1_q <= icache_rdata[31:0];
                // An upper-half fetch only yields one useful word.
                if (!req_pc[2]) begin
                  wr_en2_q   <= 1'b1;
                  wr_data2_q <= icache_rdata[63:32];
                  wr_addr2_q <= req_pc + 32'd4;
                end
                pc    <= req_pc + (req_pc[2] ? 32'd4 : 32'd8);
                state <= S_REQ;
              end
            end
          end

          S_DISCARD: begin
            if (icache_data_ok) begin
              state <= S_REQ;
            end
          end

          S_ERR_WRITE: begin
            wr_en1_q   <= 1'b1;
            wr_addr1_q <= pc;
            wr_exp_q[EXP_ADEL_BIT] <= 1'b1;
            state <= S_HALT;
          end

          S_HALT: begin
            state <= S_HALT;
          end

          default: state <= S_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit. Inputs change and outputs
// are sampled 1 ns after the rising edge.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fifo_full;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_addr_ok;
  logic        icache_data_ok;
  logic [63:0] icache_rdata;
  logic        icache_error;
  logic        write_en1;
  logic        write_en2;
  logic [31:0] write_data1;
  logic [31:0] write_address1;
  logic [31:0] write_data2;
  logic [31:0] write_address2;
  logic [11:0] write_inst_exp1;

  int n_checks = 0;
  int n_pass   = 0;

  instruction_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .fifo_full       (fifo_full),
    .icache_req      (icache_req),
    .icache_addr     (icache_addr),
    .icache_addr_ok  (icache_addr_ok),
    .icache_data_ok  (icache_data_ok),
    .icache_rdata    (icache_rdata),
    .icache_error    (icache_error),
    .write_en1       (write_en1),
    .write_en2       (write_en2),
    .write_data1     (write_data1),
    .write_address1  (write_address1),
    .write_data2     (write_data2),
    .write_address2  (write_address2),
    .write_inst_exp1 (write_inst_exp1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Check the full write port in one go.
  task automatic check_write(input string tag, input logic en1, input logic en2,
                             input logic [31:0] d1, input logic [31:0] a1,
                             input logic [31:0] d2, input logic [31:0] a2,
                             input logic [11:0] exp);
    check({tag, ".en1"},   write_en1, en1);
    check({tag, ".en2"},   write_en2, en2);
    check({tag, ".data1"}, write_data1, d1);
    check({tag, ".addr1"}, write_address1, a1);
    check({tag, ".data2"}, write_data2, d2);
    check({tag, ".addr2"}, write_address2, a2);
    check({tag, ".exp"},   write_inst_exp1, exp);
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fifo_full      = 1'b0;
    icache_addr_ok = 1'b0;
    icache_data_ok = 1'b0;
    icache_rdata   = '0;
    icache_error   = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst.req", icache_req, 1'b0);
    check("rst.addr", icache_addr, 32'hBFC0_0000);
    check_write("rst", 0, 0, 0, 0, 0, 0, 12'h000);

    // Test 1: first fetch, full 8-byte pair.
    rst = 1'b0;
    icache_addr_ok = 1'b1;
    settle();
    check("t1.req_after_rst", icache_req, 1'b0);
    tick();
    check("t1.req", icache_req, 1'b1);
    check("t1.addr", icache_addr, 32'hBFC0_0000);
    tick();
    icache_addr_ok = 1'b0;
    icache_data_ok = 1'b1;
    icache_rdata   = 64'h2400_0002_2400_0001;
    settle();
    check("t1.wait_req", icache_req, 1'b0);
    tick();
    icache_data_ok = 1'b0;
    settle();
    check_write("t1", 1, 1, 32'h2400_0001, 32'hBFC0_0000,
                32'h2400_0002, 32'hBFC0_0004, 12'h000);
    check("t1.next_addr", icache_addr, 32'hBFC0_0008);
    check("t1.next_req", icache_req, 1'b1);

    // Test 2: redirect to an upper-half address, single write.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0004;
    tick();
    redirect_valid = 1'b0;
    icache_addr_ok = 1'b1;
    settle();
    check("t2.addr", icache_addr, 32'h8000_0004);
    tick();
    icache_addr_ok = 1'b0;
    icache_data_ok = 1'b1;
    icache_rdata   = 64'h1111_1111_2222_2222;
    tick();
    icache_data_ok = 1'b0;
    settle();
    check_write("t2", 1, 0, 32'h2222_2222, 32'h8000_0004, 0, 0, 12'h000);
    check("t2.next_addr", icache_addr, 32'h8000_0008);
    // A redirect in the write cycle masks the write.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0008;
    settle();
    check("t2.mask_en1", write_en1, 1'b0);
    check("t2.mask_data1", write_data1, 32'h0);

    // Test 3: redirect while waiting, late response discarded.
    tick();
    redirect_valid = 1'b0;
    icache_addr_ok = 1'b1;
    tick();
    icache_addr_ok = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    settle();
    check("t3.discard_req", icache_req, 1'b0);
    check("t3.discard_addr", icache_addr, 32'h8000_1000);
    tick();
    tick();
    icache_data_ok = 1'b1;
    icache_rdata   = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    icache_data_ok = 1'b0;
    settle();
    check("t3.no_write", write_en1, 1'b0);
    check("t3.req", icache_req, 1'b1);
    check("t3.addr", icache_addr, 32'h8000_1000);

    // Test 4: redirect in the same cycle as the accepted handshake.
    icache_addr_ok = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2000;
    settle();
    check("t4.req", icache_req, 1'b1);
    tick();
    icache_addr_ok = 1'b0;
    redirect_valid = 1'b0;
    settle();
    check("t4.discard_req", icache_req, 1'b0);
    icache_data_ok = 1'b1;
    icache_rdata   = 64'h0BAD_0BAD_0BAD_0BAD;
    tick();
    icache_data_ok = 1'b0;
    settle();
    check("t4.no_write", write_en1, 1'b0);
    check("t4.addr", icache_addr, 32'h8000_2000);
    check("t4.req_again", icache_req, 1'b1);

    // Test 5: fifo_full gates issue; rising in WAIT does not block the write.
    fifo_full = 1'b1;
    settle();
    check("t5.full_req", icache_req, 1'b0);
    tick();
    tick();
    check("t5.full_req2", icache_req, 1'b0);
    check("t5.full_addr", icache_addr, 32'h8000_2000);
    fifo_full = 1'b0;
    settle();
    check("t5.req_back", icache_req, 1'b1);
    check("t5.addr_back", icache_addr, 32'h8000_2000);
    icache_addr_ok = 1'b1;
    tick();
    icache_addr_ok = 1'b0;
    fifo_full      = 1'b1;
    icache_data_ok = 1'b1;
    icache_rdata   = 64'hAAAA_0000_BBBB_0000;
    tick();
    icache_data_ok = 1'b0;
    fifo_full      = 1'b0;
    settle();
    check_write("t5", 1, 1, 32'hBBBB_0000, 32'h8000_2000,
                32'hAAAA_0000, 32'h8000_2004, 12'h000);
    check("t5.next_addr", icache_addr, 32'h8000_2008);

    // Test 6: misaligned redirect -> address error, then halt.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0002;
    tick();
    redirect_valid = 1'b0;
    settle();
    check("t6.no_req", icache_req, 1'b0);
    tick();
    check("t6.err_cycle_en1", write_en1, 1'b0);
    tick();
    check_write("t6.adel", 1, 0, 0, 32'h8000_0002, 0, 0, 12'h001);
    tick();
    check("t6.halt_en1", write_en1, 1'b0);
    check("t6.halt_req", icache_req, 1'b0);
    icache_data_ok = 1'b1;
    tick();
    icache_data_ok = 1'b0;
    settle();
    check("t6.halt_ignore", write_en1, 1'b0);

    // Bus error response on a later fetch.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_3000;
    tick();
    redirect_valid = 1'b0;
    icache_addr_ok = 1'b1;
    settle();
    check("t6.req_after_halt", icache_req, 1'b1);
    tick();
    icache_addr_ok = 1'b0;
    icache_data_ok = 1'b1;
    icache_error   = 1'b1;
    icache_rdata   = 64'h1234_5678_9ABC_DEF0;
    tick();
    icache_data_ok = 1'b0;
    icache_error   = 1'b0;
    settle();
    check_write("t6.ibe", 1, 0, 0, 32'h8000_3000, 0, 0, 12'h002);
    check("t6.ibe_halt_req", icache_req, 1'b0);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    icache_addr_ok = 1'b1;
    tick();
    icache_addr_ok = 1'b0;
    icache_data_ok = 1'b1;
    icache_rdata   = 64'h0000_0004_0000_0003;
    tick();
    icache_data_ok = 1'b0;
    settle();
    check_write("wrap", 1, 1, 32'h0000_0003, 32'hFFFF_FFF8,
                32'h0000_0004, 32'hFFFF_FFFC, 12'h000);
    check("wrap.next_addr", icache_addr, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
